// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register with branch/JAL/JALR resolution, fetch handshake, boot delay and misaligned-target trap
module pc_next_unit #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
   parameter int RESET_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      pc_mux_control,
   input  logic [2:0]      branch_funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            instr_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_valid,
   output logic            taken,
   output logic            misaligned_exc,
   output logic [XLEN-1:0] epc
);
   typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
   localparam logic [7:0] CNT_INIT = 8'(RESET_CYCLES - 1);
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, target, next_pc;
   logic fv_q, exc_q, cond, mis, adv;
   assign pc = pc_q;
   assign epc = epc_q;
   assign fetch_valid = fv_q;
   assign misaligned_exc = exc_q;
   assign pc_plus4 = pc_q + XLEN'(4);
   assign adv = instr_valid & fetch_ready;
   always_comb begin
      cond = branch_funct3[2] ? ((branch_funct3[1] ? (rs1_data < rs2_data)
                                                    : ($signed(rs1_data) < $signed(rs2_data))) ^ branch_funct3[0])
                              : (branch_funct3[1] ? 1'b0 : ((rs1_data == rs2_data) ^ branch_funct3[0]));
      taken = (pc_mux_control == 2'b01) ? cond : pc_mux_control[1];
      target = (pc_mux_control == 2'b11) ? ((rs1_data + imm) & ~{{(XLEN-1){1'b0}}, 1'b1}) : pc_q + imm;
      next_pc = taken ? target : pc_plus4;
      mis = taken & |target[1:0];
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pc_d = pc_q;
      epc_d = epc_q;
      case (state_q)
         BOOT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd0) state_d = RUN;
         end
         RUN: if (adv) begin
            // A misaligned target is never loaded; the trap vector replaces it
            pc_d = mis ? TRAP_VECTOR : next_pc;
            epc_d = mis ? pc_q : epc_q;
            state_d = mis ? TRAP : RUN;
         end
         default: state_d = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         cnt_q <= CNT_INIT;
         pc_q <= RESET_VECTOR;
         epc_q <= '0;
         fv_q <= 1'b0;
         exc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         pc_q <= pc_d;
         epc_q <= epc_d;
         fv_q <= (state_d == RUN);
         exc_q <= (state_d == TRAP);
      end
   end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed vectors with hand-computed expectations for pc_next_unit
module tb_pc_next_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] pc_mux_control = 2'b00;
   logic [2:0] branch_funct3 = 3'b000;
   logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
   logic instr_valid = 1'b1, fetch_ready = 1'b1;
   logic [31:0] pc, pc_plus4, epc;
   logic fetch_valid, taken, misaligned_exc;
   int n_chk = 0, n_pass = 0;
   pc_next_unit dut (
      .clk(clk), .rst(rst), .pc_mux_control(pc_mux_control), .branch_funct3(branch_funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .instr_valid(instr_valid),
      .fetch_ready(fetch_ready), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
      .taken(taken), .misaligned_exc(misaligned_exc), .epc(epc)
   );
   always #5 clk = ~clk;
   task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask
   task drive(input logic [1:0] m, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
              input logic [31:0] i, input logic v, input logic r);
      @(negedge clk);
      pc_mux_control = m;
      branch_funct3 = f;
      rs1_data = a;
      rs2_data = b;
      imm = i;
      instr_valid = v;
      fetch_ready = r;
      #1;
   endtask
   task tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
      chk("rst_exc", {31'b0, misaligned_exc}, 32'h0);
      chk("rst_epc", epc, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("boot_fv", {31'b0, fetch_valid}, 32'h0);
         chk("boot_pc", pc, 32'h0);
      end
      tick;
      chk("run_fv", {31'b0, fetch_valid}, 32'h1);
      chk("run_pc0", pc, 32'h0);
      tick;
      chk("seq_4", pc, 32'h4);
      tick;
      chk("seq_8", pc, 32'h8);
      drive(2'b10, 3'b000, 0, 0, 32'h38, 1, 1);
      chk("jal_taken", {31'b0, taken}, 32'h1);
      tick;
      chk("jal_40", pc, 32'h40);
      drive(2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h10, 1, 1);
      chk("blt_taken", {31'b0, taken}, 32'h1);
      tick;
      chk("blt_pc", pc, 32'h50);
      drive(2'b10, 3'b000, 0, 0, 32'hFFFF_FFF0, 1, 1);
      tick;
      chk("jal_back", pc, 32'h40);
      drive(2'b01, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h10, 1, 1);
      chk("bltu_taken", {31'b0, taken}, 32'h0);
      tick;
      chk("bltu_pc", pc, 32'h44);
      drive(2'b11, 3'b000, 32'h1001, 0, 32'h4, 1, 1);
      chk("jalr_link", pc_plus4, 32'h48);
      chk("jalr_taken", {31'b0, taken}, 32'h1);
      tick;
      chk("jalr_pc", pc, 32'h1004);
      chk("jalr_noexc", {31'b0, misaligned_exc}, 32'h0);
      drive(2'b10, 3'b000, 0, 0, 32'hFFFF_F07C, 1, 1);
      tick;
      chk("jal_80", pc, 32'h80);
      drive(2'b10, 3'b000, 0, 0, 32'h6, 1, 1);
      chk("mis_taken", {31'b0, taken}, 32'h1);
      tick;
      chk("trap_exc", {31'b0, misaligned_exc}, 32'h1);
      chk("trap_epc", epc, 32'h80);
      chk("trap_pc", pc, 32'h100);
      chk("trap_fv", {31'b0, fetch_valid}, 32'h0);
      drive(2'b00, 3'b000, 0, 0, 0, 1, 1);
      tick;
      chk("post_exc", {31'b0, misaligned_exc}, 32'h0);
      chk("post_fv", {31'b0, fetch_valid}, 32'h1);
      chk("post_pc", pc, 32'h100);
      drive(2'b01, 3'b000, 32'h5, 32'h5, 32'h20, 1, 0);
      for (int k = 0; k < 3; k++) begin
         chk("stall_taken", {31'b0, taken}, 32'h1);
         tick;
         chk("stall_pc", pc, 32'h100);
      end
      drive(2'b01, 3'b000, 32'h5, 32'h5, 32'h20, 1, 1);
      tick;
      chk("beq_pc", pc, 32'h120);
      drive(2'b01, 3'b001, 32'h5, 32'h5, 32'h20, 1, 1);
      chk("bne_taken", {31'b0, taken}, 32'h0);
      tick;
      chk("bne_pc", pc, 32'h124);
      drive(2'b01, 3'b010, 32'h1, 32'h2, 32'h20, 1, 1);
      chk("f010_taken", {31'b0, taken}, 32'h0);
      tick;
      chk("f010_pc", pc, 32'h128);
      drive(2'b01, 3'b101, 32'h0, 32'hFFFF_FFFF, 32'h8, 1, 1);
      chk("bge_taken", {31'b0, taken}, 32'h1);
      tick;
      chk("bge_pc", pc, 32'h130);
      drive(2'b00, 3'b000, 0, 0, 0, 0, 1);
      tick;
      chk("iv0_hold", pc, 32'h130);
      drive(2'b11, 3'b000, 32'h1003, 0, 0, 1, 1);
      tick;
      chk("jalr_mis_exc", {31'b0, misaligned_exc}, 32'h1);
      chk("jalr_mis_epc", epc, 32'h130);
      chk("jalr_mis_pc", pc, 32'h100);
      drive(2'b00, 3'b000, 0, 0, 0, 1, 1);
      tick;
      drive(2'b10, 3'b000, 0, 0, 32'hFFFF_FEFC, 1, 1);
      tick;
      chk("jal_top", pc, 32'hFFFF_FFFC);
      drive(2'b00, 3'b000, 0, 0, 0, 1, 1);
      chk("wrap_plus4", pc_plus4, 32'h0);
      tick;
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_noexc", {31'b0, misaligned_exc}, 32'h0);
      drive(2'b10, 3'b000, 0, 0, 32'h2, 1, 1);
      tick;
      chk("trap2_exc", {31'b0, misaligned_exc}, 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_exc", {31'b0, misaligned_exc}, 32'h0);
      chk("arst_epc", epc, 32'h0);
      chk("arst_fv", {31'b0, fetch_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
